// File: rtl/gpmc_pkg.sv
// Shared definitions for the Wishbone-to-GPMC master: state encoding,
// default phase timings and the phase counter width.
package gpmc_pkg;

  localparam int unsigned CNT_W = 4;

  localparam int unsigned DEF_ADDR_CYCLES   = 2;
  localparam int unsigned DEF_ACCESS_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES   = 1;
  localparam int unsigned DEF_TURN_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACCESS,
    ST_HOLD,
    ST_ACK,
    ST_TURN
  } state_e;

  // Reload value for a phase that lasts 'cycles' clocks.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned cycles);
    return CNT_W'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/gpmc_phase_timer.sv
// Loadable down-counter that flags the last cycle of the current phase.
module gpmc_phase_timer
  import gpmc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // done is registered from the next count so it marks the phase's final cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/wishbone_to_gpmc.sv
// Wishbone slave that runs one asynchronous multiplexed GPMC access per
// transfer; the AD pad is split into in/out/oe for a top-level tristate.
module wishbone_to_gpmc
  import gpmc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_CYCLES   = DEF_ADDR_CYCLES,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned TURN_CYCLES   = DEF_TURN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_cycle,
  input  logic                  wbs_strobe,
  input  logic                  wbs_write,
  output logic                  wbs_ack,
  output logic [DATA_WIDTH-1:0] gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
  output logic                  gpmc_advn,
  output logic                  gpmc_csn,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  abort_q, abort_d;
  logic                  cap_q, cap_d;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] ad_out_q, ad_out_d;
  logic                  ack_q, ack_d;
  logic                  ad_oe_q, ad_oe_d;
  logic                  advn_q, advn_d;
  logic                  csn_q, csn_d;
  logic                  wein_q, wein_d;
  logic                  oen_q, oen_d;

  logic                  timer_load;
  logic [CNT_W-1:0]      timer_val;
  logic                  timer_done;

  gpmc_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  // Phase sequencing; the request is only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    abort_d    = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (wbs_cycle && wbs_strobe) begin
          state_d    = ST_ADDR;
          timer_load = 1'b1;
          timer_val  = phase_load(ADDR_CYCLES);
          addr_d     = wbs_address;
          wdata_d    = wbs_writedata;
          write_d    = wbs_write;
          abort_d    = 1'b0;
        end
      end
      ST_ADDR: begin
        if (timer_done) begin
          state_d    = ST_ACCESS;
          timer_load = 1'b1;
          timer_val  = phase_load(ACCESS_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (timer_done) begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = phase_load(HOLD_CYCLES);
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d    = ST_TURN;
        timer_load = 1'b1;
        timer_val  = phase_load(TURN_CYCLES);
      end
      ST_TURN: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A dropped cycle only suppresses the ack; the external access runs to completion.
    if ((state_q inside {ST_ADDR, ST_ACCESS, ST_HOLD}) && !wbs_cycle) begin
      abort_d = 1'b1;
    end
  end

  // Pin values follow the state one cycle later; read data is taken on the last ACCESS cycle.
  always_comb begin
    csn_d    = 1'b1;
    advn_d   = 1'b1;
    wein_d   = 1'b1;
    oen_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    ack_d    = 1'b0;
    cap_d    = (state_q == ST_ACCESS) && timer_done && !write_q;
    rdata_d  = cap_q ? gpmc_ad_in : rdata_q;
    case (state_q)
      ST_ADDR: begin
        csn_d    = 1'b0;
        advn_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = DATA_WIDTH'(addr_q);
      end
      ST_ACCESS: begin
        csn_d = 1'b0;
        if (write_q) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_q;
          wein_d   = 1'b0;
        end else begin
          oen_d = 1'b0;
        end
      end
      ST_HOLD: begin
        csn_d = 1'b0;
        if (write_q) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_q;
        end
      end
      ST_ACK:  ack_d = !abort_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      abort_q  <= 1'b0;
      cap_q    <= 1'b0;
      rdata_q  <= '0;
      ad_out_q <= '0;
      ack_q    <= 1'b0;
      ad_oe_q  <= 1'b0;
      advn_q   <= 1'b1;
      csn_q    <= 1'b1;
      wein_q   <= 1'b1;
      oen_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      abort_q  <= abort_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      ack_q    <= ack_d;
      ad_oe_q  <= ad_oe_d;
      advn_q   <= advn_d;
      csn_q    <= csn_d;
      wein_q   <= wein_d;
      oen_q    <= oen_d;
    end
  end

  assign wbs_readdata = rdata_q;
  assign wbs_ack      = ack_q;
  assign gpmc_ad_out  = ad_out_q;
  assign gpmc_ad_oe   = ad_oe_q;
  assign gpmc_advn    = advn_q;
  assign gpmc_csn     = csn_q;
  assign gpmc_wein    = wein_q;
  assign gpmc_oen     = oen_q;

endmodule

// File: tb/tb_wishbone_to_gpmc.sv
// Bench for wishbone_to_gpmc: a default-timing and an all-ones-timing instance
// share stimulus and are checked every cycle against a schedule model.
module tb_wishbone_to_gpmc;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_wdat;
  logic [DW-1:0] ad_in;
  logic          wb_cyc, wb_stb, wb_we;

  logic [DW-1:0] rdata  [2];
  logic [DW-1:0] ad_out [2];
  logic [1:0]    ack, ad_oe, advn, csn, wein, oen;

  always #5 clk = ~clk;

  wishbone_to_gpmc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .wbs_address(wb_adr), .wbs_writedata(wb_wdat),
    .wbs_readdata(rdata[0]), .wbs_cycle(wb_cyc), .wbs_strobe(wb_stb),
    .wbs_write(wb_we), .wbs_ack(ack[0]), .gpmc_ad_out(ad_out[0]),
    .gpmc_ad_oe(ad_oe[0]), .gpmc_ad_in(ad_in), .gpmc_advn(advn[0]),
    .gpmc_csn(csn[0]), .gpmc_wein(wein[0]), .gpmc_oen(oen[0])
  );

  wishbone_to_gpmc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_CYCLES(1),
                     .ACCESS_CYCLES(1), .HOLD_CYCLES(1), .TURN_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .wbs_address(wb_adr), .wbs_writedata(wb_wdat),
    .wbs_readdata(rdata[1]), .wbs_cycle(wb_cyc), .wbs_strobe(wb_stb),
    .wbs_write(wb_we), .wbs_ack(ack[1]), .gpmc_ad_out(ad_out[1]),
    .gpmc_ad_oe(ad_oe[1]), .gpmc_ad_in(ad_in), .gpmc_advn(advn[1]),
    .gpmc_csn(csn[1]), .gpmc_wein(wein[1]), .gpmc_oen(oen[1])
  );

  int errors = 0;
  int checks = 0;
  int k = 0;

  int pa [2] = '{2, 1};
  int pc [2] = '{4, 1};
  int ph [2] = '{1, 1};
  int pt [2] = '{2, 1};

  bit          busy  [2];
  bit          abrt  [2];
  bit          mwr   [2];
  int          e0    [2];
  int          nacc  [2];
  logic [15:0] maddr [2];
  logic [15:0] mdata [2];
  logic [15:0] mrd   [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at edge %0d", name, got, exp, k);
    end
  endtask

  // 0 idle, 1 address, 2 access, 3 hold, 4 ack -- cycle n counted from the accept edge.
  function automatic int phase_of(input int i, input int n);
    if (!busy[i]) return 0;
    if (n >= 1 && n <= pa[i]) return 1;
    if (n > pa[i] && n <= pa[i] + pc[i]) return 2;
    if (n > pa[i] + pc[i] && n <= pa[i] + pc[i] + ph[i]) return 3;
    if (n == pa[i] + pc[i] + ph[i] + 1) return 4;
    return 0;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        busy[i] = 1'b0;
        nacc[i] = k + 1;
        mrd[i]  = '0;
      end else begin
        if (busy[i]) begin
          int n;
          n = k - e0[i];
          if (n >= 1 && n <= pa[i] + pc[i] + ph[i] && !wb_cyc) abrt[i] = 1'b1;
          if (n == pa[i] + pc[i] + 1 && !mwr[i]) mrd[i] = ad_in;
          if (n >= pa[i] + pc[i] + ph[i] + 2) busy[i] = 1'b0;
        end
        if (!busy[i] && k >= nacc[i] && wb_cyc && wb_stb) begin
          busy[i]  = 1'b1;
          e0[i]    = k;
          nacc[i]  = k + pa[i] + pc[i] + ph[i] + 2 + pt[i];
          maddr[i] = wb_adr;
          mdata[i] = wb_wdat;
          mwr[i]   = wb_we;
          abrt[i]  = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int         p;
      logic       x_csn, x_advn, x_wein, x_oen, x_oe, x_ack;
      logic [5:0] x_ctl;
      p      = phase_of(i, k - e0[i]);
      x_csn  = !(p >= 1 && p <= 3);
      x_advn = !(p == 1);
      x_wein = !(p == 2 && mwr[i]);
      x_oen  = !(p == 2 && !mwr[i]);
      x_oe   = (p == 1) || ((p == 2 || p == 3) && mwr[i]);
      x_ack  = (p == 4) && !abrt[i];
      x_ctl  = {x_csn, x_advn, x_wein, x_oen, x_oe, x_ack};
      check($sformatf("model_ctl%0d{csn,advn,wein,oen,oe,ack}", i),
            32'({csn[i], advn[i], wein[i], oen[i], ad_oe[i], ack[i]}), 32'(x_ctl));
      check($sformatf("model_rdata%0d", i), 32'(rdata[i]), 32'(mrd[i]));
      if (x_oe)
        check($sformatf("model_ad_out%0d", i), 32'(ad_out[i]),
              32'((p == 1) ? maddr[i] : mdata[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic request(input logic [15:0] a, input logic [15:0] d, input logic we);
    wb_adr  = a;
    wb_wdat = d;
    wb_we   = we;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    wb_we   = 1'b0;
    wb_adr  = '0;
    wb_wdat = '0;
    ad_in   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_csn", 32'(csn[0]), 32'd1);
    check("rst_advn", 32'(advn[0]), 32'd1);
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_rdata", 32'(rdata[0]), 32'h0);

    // Basic write.
    request(16'h0123, 16'h00A5, 1'b1);
    wb_stb = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n <= 2) begin
        check("wr_advn", 32'(advn[0]), 32'd0);
        check("wr_addr", 32'(ad_out[0]), 32'h0123);
      end
      if (n >= 3 && n <= 6) begin
        check("wr_wein", 32'(wein[0]), 32'd0);
        check("wr_data", 32'(ad_out[0]), 32'h00A5);
      end
      check("wr_csn", 32'(csn[0]), (n <= 7) ? 32'd0 : 32'd1);
      check("wr_ack", 32'(ack[0]), (n == 8) ? 32'd1 : 32'd0);
      check("fast_ack", 32'(ack[1]), (n == 4) ? 32'd1 : 32'd0);
    end
    wb_cyc = 1'b0;
    tick();

    // Basic read.
    ad_in = 16'hBEEF;
    request(16'h0040, 16'h0000, 1'b0);
    wb_stb = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n >= 3 && n <= 6) begin
        check("rd_oen", 32'(oen[0]), 32'd0);
        check("rd_oe", 32'(ad_oe[0]), 32'd0);
      end
      if (n == 8) begin
        check("rd_data", 32'(rdata[0]), 32'hBEEF);
        check("rd_ack", 32'(ack[0]), 32'd1);
      end
    end
    wb_cyc = 1'b0;
    repeat (4) tick();

    // Back-to-back writes with strobe held.
    request(16'h0300, 16'h1111, 1'b1);
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n >= 8) check("b2b_gap_csn", 32'(csn[0]), 32'd1);
      if (n == 1) begin
        wb_adr  = 16'h0400;
        wb_wdat = 16'h2222;
      end
      if (n == 11) wb_stb = 1'b0;
    end
    for (int n = 12; n <= 22; n++) begin
      tick();
      if (n == 11 + 1) begin
        check("b2b_advn", 32'(advn[0]), 32'd0);
        check("b2b_addr", 32'(ad_out[0]), 32'h0400);
      end
      if (n == 14) check("b2b_data", 32'(ad_out[0]), 32'h2222);
      if (n == 19) check("b2b_ack", 32'(ack[0]), 32'd1);
    end
    wb_cyc = 1'b0;
    repeat (3) tick();

    // Abort: cycle dropped during cycle 4.
    request(16'h0123, 16'h00A5, 1'b1);
    wb_stb = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 2) check("ab_advn", 32'(advn[0]), 32'd0);
      if (n == 3) check("ab_data", 32'(ad_out[0]), 32'h00A5);
      if (n == 7) check("ab_csn", 32'(csn[0]), 32'd0);
      if (n == 8) check("ab_noack", 32'(ack[0]), 32'd0);
      if (n == 4) wb_cyc = 1'b0;
      if (n == 5) wb_cyc = 1'b1;
    end
    request(16'h0077, 16'h0707, 1'b1);
    wb_stb = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 8) check("ab_next_ack", 32'(ack[0]), 32'd1);
    end
    wb_cyc = 1'b0;
    repeat (4) tick();

    // Reset in cycle 5 of a read.
    ad_in = 16'hBEEF;
    request(16'h0040, 16'h0000, 1'b0);
    wb_stb = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 6) begin
        check("rst_mid_ctl", 32'({csn[0], advn[0], wein[0], oen[0], ad_oe[0]}), 32'b11110);
        check("rst_mid_rdata", 32'(rdata[0]), 32'h0);
        reset = 1'b0;
      end
      if (n >= 7) check("rst_mid_noack", 32'(ack[0]), 32'd0);
      if (n == 5) reset = 1'b1;
    end
    wb_cyc = 1'b0;
    tick();
    ad_in = 16'h1234;
    request(16'h0055, 16'h0000, 1'b0);
    wb_stb = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 8) begin
        check("post_rst_rdata", 32'(rdata[0]), 32'h1234);
        check("post_rst_ack", 32'(ack[0]), 32'd1);
      end
    end
    wb_cyc = 1'b0;
    repeat (4) tick();

    // All-ones timing: ack in cycle 4, next accept at E6.
    request(16'h0010, 16'h0F0F, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 4) check("fast_ack4", 32'(ack[1]), 32'd1);
      if (n == 5) check("fast_turn_csn", 32'(csn[1]), 32'd1);
      if (n == 6) check("fast_idle_advn", 32'(advn[1]), 32'd1);
      if (n == 7) check("fast_reaccept_advn", 32'(advn[1]), 32'd0);
      if (n == 6) wb_stb = 1'b0;
    end
    wb_cyc = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
